// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register sitting directly behind the decode control unit.
// Latches decoded control bundles, operands and register fields, inserts
// bubbles on load-use hazards and branch/jump flushes, and traps decode
// exceptions with a two-state (RUN/TRAP) EPC capture FSM.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_*                  decode-slot instruction, PC, operands, immediate
//   control_*             decoded control bundles and exception request
//   flush                 branch/jump taken: kill the decode slot
//   ex_hold               downstream stall: freeze the EX register
//   exc_ack               handler accepted the pending exception
//   ex_*                  registered EX-slot contents
//   stall_id              combinational: hold PC and IF/ID this cycle
//   exc_pending, epc      trap status and PC of the trapped instruction
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit LOADUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        control_exe,
  input  logic [2:0]        control_mem,
  input  logic [1:0]        control_wb,
  input  logic              control_exception,
  input  logic [1:0]        control_datamem,
  input  logic [1:0]        control_reg2,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              exc_ack,
  output logic              ex_valid,
  output logic [3:0]        ex_control_exe,
  output logic [2:0]        ex_control_mem,
  output logic [1:0]        ex_control_wb,
  output logic [1:0]        ex_datamem,
  output logic [1:0]        ex_reg2,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall_id,
  output logic              exc_pending,
  output logic [DATA_W-1:0] epc
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [3:0]          exe_q, exe_d;
  logic [2:0]          mem_q, mem_d;
  logic [1:0]          wb_q, wb_d;
  logic [1:0]          dm_q, dm_d;
  logic [1:0]          r2_q, r2_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0]   rs_q, rs_d;
  logic [REG_AW-1:0]   rt_q, rt_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   epc_q, epc_d;

  logic [5:0]          op;
  logic [REG_AW-1:0]   id_rs, id_rt, id_rd;
  logic                uses_rt;
  logic                hazard;

  assign op    = id_instr[31:26];
  assign id_rs = id_instr[21 +: REG_AW];
  assign id_rt = id_instr[16 +: REG_AW];
  assign id_rd = id_instr[11 +: REG_AW];

  // R-type, beq, bne and the stores read rt as a source operand.
  assign uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) ||
                   (op == 6'd40) || (op == 6'd41) || (op == 6'd43);

  // A load in EX whose destination feeds the decode instruction.
  assign hazard = LOADUSE_EN && valid_q && mem_q[0] && (rt_q != '0) && id_valid &&
                  ((rt_q == id_rs) || (uses_rt && (rt_q == id_rt)));

  // Gated by rst_n so a held ex_hold cannot leak out during reset.
  assign stall_id = rst_n & (hazard | ex_hold | (state_q == TRAP));

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    exe_d   = exe_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    dm_d    = dm_q;
    r2_d    = r2_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    epc_d   = epc_q;

    // The acknowledge returns the FSM to RUN even under ex_hold.
    if ((state_q == TRAP) && exc_ack) begin
      state_d = RUN;
    end

    if (ex_hold) begin
      // EX register keeps its contents.
    end else if (flush || (state_q == TRAP) || hazard ||
                 (id_valid && control_exception)) begin
      valid_d = 1'b0;
      exe_d   = '0;
      mem_d   = '0;
      wb_d    = '0;
      dm_d    = '0;
      r2_d    = '0;
      pc_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      // A trap is taken only when nothing of higher priority claimed the slot.
      if (!flush && (state_q == RUN) && !hazard) begin
        epc_d   = id_pc;
        state_d = TRAP;
      end
    end else begin
      valid_d = id_valid;
      exe_d   = control_exe;
      mem_d   = control_mem;
      wb_d    = control_wb;
      dm_d    = control_datamem;
      r2_d    = control_reg2;
      pc_d    = id_pc;
      rd1_d   = id_rdata1;
      rd2_d   = id_rdata2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      exe_q   <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      dm_q    <= '0;
      r2_q    <= '0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      dm_q    <= dm_d;
      r2_q    <= r2_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      epc_q   <= epc_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_control_exe = exe_q;
  assign ex_control_mem = mem_q;
  assign ex_control_wb  = wb_q;
  assign ex_datamem     = dm_q;
  assign ex_reg2        = r2_q;
  assign ex_pc          = pc_q;
  assign ex_rdata1      = rd1_q;
  assign ex_rdata2      = rd2_q;
  assign ex_imm         = imm_q;
  assign ex_rs          = rs_q;
  assign ex_rt          = rt_q;
  assign ex_rd          = rd_q;
  assign exc_pending    = (state_q == TRAP);
  assign epc            = epc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_rdata1, id_rdata2, id_imm;
  logic [3:0]  control_exe;
  logic [2:0]  control_mem;
  logic [1:0]  control_wb, control_datamem, control_reg2;
  logic        control_exception, flush, ex_hold, exc_ack;
  logic        ex_valid;
  logic [3:0]  ex_control_exe;
  logic [2:0]  ex_control_mem;
  logic [1:0]  ex_control_wb, ex_datamem, ex_reg2;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall_id, exc_pending;
  logic [31:0] epc;

  typedef struct packed {
    logic        valid;
    logic [3:0]  exe;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [1:0]  dm;
    logic [1:0]  r2;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;

  ex_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .LOADUSE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .control_exe(control_exe), .control_mem(control_mem), .control_wb(control_wb),
    .control_exception(control_exception), .control_datamem(control_datamem),
    .control_reg2(control_reg2), .flush(flush), .ex_hold(ex_hold), .exc_ack(exc_ack),
    .ex_valid(ex_valid), .ex_control_exe(ex_control_exe), .ex_control_mem(ex_control_mem),
    .ex_control_wb(ex_control_wb), .ex_datamem(ex_datamem), .ex_reg2(ex_reg2),
    .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_id(stall_id),
    .exc_pending(exc_pending), .epc(epc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h000};
  endfunction

  function automatic ex_t observed();
    return '{ex_valid, ex_control_exe, ex_control_mem, ex_control_wb, ex_datamem,
             ex_reg2, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd};
  endfunction

  // Expected EX contents when the currently driven decode slot is loaded.
  function automatic ex_t exp_load();
    return '{id_valid, control_exe, control_mem, control_wb, control_datamem,
             control_reg2, id_pc, id_rdata1, id_rdata2, id_imm,
             id_instr[25:21], id_instr[20:16], id_instr[15:11]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [3:0] exe, input logic [2:0] mem, input logic [1:0] wb,
                       input logic exc);
    id_valid          = v;
    id_instr          = instr;
    id_pc             = pc;
    id_rdata1         = pc ^ 32'h1111_0000;
    id_rdata2         = pc ^ 32'h0000_2222;
    id_imm            = {16'h0, pc[15:0]} + 32'h4;
    control_exe       = exe;
    control_mem       = mem;
    control_wb        = wb;
    control_datamem   = mem[0] ? 2'b10 : 2'b00;
    control_reg2      = mem[1] ? 2'b01 : 2'b00;
    control_exception = exc;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 2'h0, 1'b0);
  endtask

  // Advance one edge and compare the EX register against the oldest expectation.
  task automatic step_cmp(input string name);
    ex_t e, o;
    @(posedge clk);
    #1;
    n_checks++;
    o = observed();
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %h", name, o);
    end else begin
      e = sb_q.pop_front();
      if (o !== e) $display("FAIL %s: ex got %h expected %h", name, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; ex_hold = 1'b1; exc_ack = 0;
    drive(1'b1, mk(6'd35, 5'd9, 5'd8, 5'd0), 32'h0040_0000, 4'h2, 3'b001, 2'b11, 1'b1);
    #12;
    n_checks++;
    if (observed() !== '0) $display("FAIL reset_ex: got %h expected 0", observed());
    else n_pass++;
    n_checks++;
    if ({stall_id, exc_pending, epc} !== 34'h0)
      $display("FAIL reset_status: got stall=%b pend=%b epc=%h expected 0 0 0",
               stall_id, exc_pending, epc);
    else n_pass++;
    ex_hold = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    drive(1'b1, mk(6'd35, 5'd9, 5'd8, 5'd0), 32'h0040_0000, 4'h2, 3'b001, 2'b11, 1'b0);
    sb_q.push_back(exp_load());
    step_cmp("t1_lw");
    drive(1'b1, mk(6'd0, 5'd8, 5'd1, 5'd10), 32'h0040_0004, 4'h8, 3'b000, 2'b01, 1'b0);
    #1;
    n_checks++;
    if (stall_id !== 1'b1) $display("FAIL t1_stall: got %b expected 1", stall_id);
    else n_pass++;
    sb_q.push_back('0);
    step_cmp("t1_bubble");
    n_checks++;
    if (stall_id !== 1'b0) $display("FAIL t1_unstall: got %b expected 0", stall_id);
    else n_pass++;
    sb_q.push_back(exp_load());
    step_cmp("t1_add");
    n_checks++;
    if (ex_rs !== 5'd8) $display("FAIL t1_rs: got %0d expected 8", ex_rs);
    else n_pass++;
  endtask

  task automatic test_no_hazard();
    drive(1'b1, mk(6'd35, 5'd9, 5'd0, 5'd0), 32'h0040_0100, 4'h2, 3'b001, 2'b11, 1'b0);
    sb_q.push_back(exp_load());
    step_cmp("t2_lw0");
    drive(1'b1, mk(6'd0, 5'd0, 5'd0, 5'd3), 32'h0040_0104, 4'h8, 3'b000, 2'b01, 1'b0);
    #1;
    n_checks++;
    if (stall_id !== 1'b0) $display("FAIL t2_zero_stall: got %b expected 0", stall_id);
    else n_pass++;
    sb_q.push_back(exp_load());
    step_cmp("t2_use0");
    drive(1'b1, mk(6'd35, 5'd9, 5'd8, 5'd0), 32'h0040_0108, 4'h2, 3'b001, 2'b11, 1'b0);
    sb_q.push_back(exp_load());
    step_cmp("t2_lw8");
    // addi writes rt=8 but does not read it.
    drive(1'b1, mk(6'd8, 5'd2, 5'd8, 5'd0), 32'h0040_010c, 4'h6, 3'b000, 2'b01, 1'b0);
    #1;
    n_checks++;
    if (stall_id !== 1'b0) $display("FAIL t2_addi_stall: got %b expected 0", stall_id);
    else n_pass++;
    sb_q.push_back(exp_load());
    step_cmp("t2_addi");
  endtask

  task automatic test_exception();
    drive(1'b1, mk(6'd0, 5'd1, 5'd2, 5'd3), 32'h0040_0010, 4'h8, 3'b000, 2'b01, 1'b1);
    sb_q.push_back('0);
    step_cmp("t3_trap");
    n_checks++;
    if ({exc_pending, epc} !== {1'b1, 32'h0040_0010})
      $display("FAIL t3_epc: got pend=%b epc=%h expected 1 00400010", exc_pending, epc);
    else n_pass++;
    drive(1'b1, mk(6'd0, 5'd4, 5'd5, 5'd6), 32'h0040_0014, 4'h8, 3'b000, 2'b01, 1'b0);
    #1;
    n_checks++;
    if (stall_id !== 1'b1) $display("FAIL t3_stall: got %b expected 1", stall_id);
    else n_pass++;
    sb_q.push_back('0);
    step_cmp("t3_wait");
    exc_ack = 1'b1;
    sb_q.push_back('0);
    step_cmp("t3_ack");
    exc_ack = 1'b0;
    n_checks++;
    if (exc_pending !== 1'b0) $display("FAIL t3_release: got %b expected 0", exc_pending);
    else n_pass++;
    sb_q.push_back(exp_load());
    step_cmp("t3_resume");
    n_checks++;
    if (epc !== 32'h0040_0010) $display("FAIL t3_epc_hold: got %h expected 00400010", epc);
    else n_pass++;
  endtask

  task automatic test_flush_hold();
    ex_t held;
    drive(1'b1, mk(6'd0, 5'd7, 5'd7, 5'd7), 32'h0000_0500, 4'h8, 3'b000, 2'b01, 1'b1);
    flush = 1'b1;
    sb_q.push_back('0);
    step_cmp("t4_flush_exc");
    flush = 1'b0;
    n_checks++;
    if ({exc_pending, epc} !== {1'b0, 32'h0040_0010})
      $display("FAIL t4_no_trap: got pend=%b epc=%h expected 0 00400010", exc_pending, epc);
    else n_pass++;
    drive(1'b1, mk(6'd43, 5'd3, 5'd4, 5'd0), 32'h0000_0600, 4'h3, 3'b010, 2'b00, 1'b0);
    held = exp_load();
    sb_q.push_back(held);
    step_cmp("t4_sw");
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(6'd0, 5'(i), 5'(i + 1), 5'd9), 32'h0000_0700 + 32'(i * 4),
            4'h8, 3'b000, 2'b01, (i == 1));
      flush = (i == 2);
      sb_q.push_back(held);
      step_cmp("t4_hold");
    end
    flush = 1'b0;
    n_checks++;
    if ({stall_id, exc_pending} !== 2'b10)
      $display("FAIL t4_hold_status: got stall=%b pend=%b expected 1 0", stall_id, exc_pending);
    else n_pass++;
    ex_hold = 1'b0;
    // Trap, then acknowledge while ex_hold is asserted.
    drive(1'b1, mk(6'd0, 5'd1, 5'd1, 5'd1), 32'h0000_0800, 4'h8, 3'b000, 2'b01, 1'b1);
    sb_q.push_back('0);
    step_cmp("t4_trap2");
    ex_hold = 1'b1; exc_ack = 1'b1;
    idle();
    sb_q.push_back('0);
    step_cmp("t4_ack_hold");
    ex_hold = 1'b0; exc_ack = 1'b0;
    n_checks++;
    if ({exc_pending, epc} !== {1'b0, 32'h0000_0800})
      $display("FAIL t4_ack_hold_state: got pend=%b epc=%h expected 0 00000800", exc_pending, epc);
    else n_pass++;
  endtask

  task automatic test_reset_in_trap();
    drive(1'b1, mk(6'd0, 5'd2, 5'd2, 5'd2), 32'h0040_0020, 4'h8, 3'b000, 2'b01, 1'b1);
    sb_q.push_back('0);
    step_cmp("t5_trap");
    n_checks++;
    if (exc_pending !== 1'b1) $display("FAIL t5_pending: got %b expected 1", exc_pending);
    else n_pass++;
    drive(1'b1, mk(6'd0, 5'd3, 5'd3, 5'd3), 32'h0040_0024, 4'h8, 3'b000, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({observed(), stall_id, exc_pending, epc} !== '0)
      $display("FAIL t5_async_reset: got ex=%h stall=%b pend=%b epc=%h expected all 0",
               observed(), stall_id, exc_pending, epc);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(exp_load());
    step_cmp("t5_resume");
    n_checks++;
    if ({exc_pending, epc} !== 33'h0)
      $display("FAIL t5_after: got pend=%b epc=%h expected 0 0", exc_pending, epc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_exception();
    test_flush_hold();
    test_reset_in_trap();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
